// File: rtl/pec_streamer_source_unpack.sv
// Input-side streamer sequencer: requests one TCDM load per element, unpacks each
// 32-bit stream word into two 16-bit channels and presents the pixel vector.
module pec_streamer_source_unpack #(
  parameter int NCH   = 16,
  parameter int CH_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [7:0]            ft_sz_i,
  input  logic [7:0]            in_sz_i,
  input  logic [31:0]           base_addr_i,
  output logic                  req_start_o,
  output logic [31:0]           addr_o,
  output logic [7:0]            trans_size_o,
  input  logic [2*CH_W-1:0]     stream_data_i,
  input  logic                  stream_valid_i,
  output logic                  stream_ready_o,
  output logic [NCH*CH_W-1:0]   pixel_o,
  output logic                  pixel_valid_o,
  input  logic                  pixel_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    SRC_IDLE    = 2'd0,
    SRC_REQ     = 2'd1,
    SRC_LOAD    = 2'd2,
    SRC_PRESENT = 2'd3
  } state_e;

  state_e                       state_q;
  logic [CNT_W-1:0]             el_cnt_q;
  logic [7:0]                   word_cnt_q;
  logic [NCH-1:0][CH_W-1:0]     pix_q, pix_d;

  logic [7:0]       ft, in_side, compr;
  logic [15:0]      n_el16;
  logic [CNT_W-1:0] n_el;
  logic [31:0]      el_off;
  logic             stream_fire, pixel_fire, last_word, last_el;

  // Layer geometry is derived live from the (stable while busy) configuration inputs.
  always_comb begin
    if (ft_sz_i == 8'd0)             ft = 8'd1;
    else if (ft_sz_i > 8'(NCH))      ft = 8'(NCH);
    else                             ft = ft_sz_i;
    in_side = (in_sz_i == 8'd0) ? 8'd1 : in_sz_i;
    compr   = (ft + 8'd1) >> 1;
    n_el16  = 16'(in_side) * 16'(in_side);
    n_el    = CNT_W'(n_el16);
    el_off  = 32'(el_cnt_q) * 32'(compr);
  end

  assign addr_o         = base_addr_i + {el_off[29:0], 2'b00};
  assign trans_size_o   = compr;
  assign stream_ready_o = (state_q == SRC_LOAD) && (word_cnt_q < compr);
  assign stream_fire    = stream_valid_i && stream_ready_o;
  assign last_word      = (word_cnt_q == compr - 8'd1);
  assign pixel_valid_o  = (state_q == SRC_PRESENT);
  assign pixel_fire     = pixel_valid_o && pixel_ready_i;
  assign last_el        = (el_cnt_q == n_el - CNT_W'(1));
  assign req_start_o    = (state_q == SRC_REQ) && !clear_i;
  assign done_o         = pixel_fire && last_el && !clear_i;
  assign busy_o         = (state_q != SRC_IDLE);
  assign state_o        = state_q;
  assign pixel_o        = pix_q;

  // Word w fills channels 2w/2w+1; channels at or above ft (incl. the odd tail) stay zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    pix_d = pix_q;
    for (int k = 0; k < NCH; k++) begin
      if (stream_fire && (word_cnt_q == 8'(k / 2)) && (8'(k) < ft)) begin
        pix_d[k] = (k % 2 == 1) ? stream_data_i[2*CH_W-1:CH_W] : stream_data_i[CH_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: the pixel buffer is plain flops, not a RAM, so it is reset like any register.
    if (!rst_ni) begin
      state_q    <= SRC_IDLE;
      el_cnt_q   <= '0;
      word_cnt_q <= '0;
      pix_q      <= '0;
    end else if (clear_i) begin
      state_q    <= SRC_IDLE;
      el_cnt_q   <= '0;
      word_cnt_q <= '0;
      pix_q      <= '0;
    end else begin
      unique case (state_q)
        SRC_IDLE: begin
          if (start_i) begin
            state_q  <= SRC_REQ;
            el_cnt_q <= '0;
          end
        end
        SRC_REQ: begin
          word_cnt_q <= '0;
          pix_q      <= '0;
          state_q    <= SRC_LOAD;
        end
        SRC_LOAD: begin
          pix_q <= pix_d;
          if (stream_fire) begin
            word_cnt_q <= word_cnt_q + 8'd1;
            if (last_word) state_q <= SRC_PRESENT;
          end
        end
        SRC_PRESENT: begin
          if (pixel_fire) begin
            if (last_el) begin
              state_q <= SRC_IDLE;
            end else begin
              el_cnt_q <= el_cnt_q + CNT_W'(1);
              state_q  <= SRC_REQ;
            end
          end
        end
        default: state_q <= SRC_IDLE;
      endcase
    end
  end

endmodule
